// File: rtl/ads1258_pkg.sv
// ADS1258 status-word layout and the decoder's FIFO entry format.
// Shared by the sample decoder, its output FIFO and the bench.
package ads1258_pkg;

    localparam int NEW_BIT = 31;
    localparam int OVF_BIT = 30;
    localparam int SUP_BIT = 29;
    localparam int CHID_HI = 28;
    localparam int CHID_LO = 24;

    localparam logic [4:0] CHID_AIN0 = 5'h08;
    localparam logic [4:0] CHID_SYS0 = 5'h18;

    localparam int ENTRY_W = 29;

    typedef struct packed {
        logic [2:0]  chan;
        logic        ovf;
        logic        supply;
        logic [23:0] data;
    } fifo_entry_t;

    function automatic logic chid_enabled(
        input logic [4:0] chid,
        input logic [4:0] base,
        input int         num
    );
        logic [5:0] c;
        logic [5:0] lo;
        logic [5:0] hi;
        c  = {1'b0, chid};
        lo = {1'b0, base};
        hi = lo + 6'(num);
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/ads1258_sample_decoder_if.sv
// Input word strobe and averaged-result stream of the sample decoder.
// master = SPI controller / formatter side, slave = decoder.
interface ads1258_sample_decoder_if;

    logic        in_valid;
    logic [31:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_chan;
    logic [23:0] out_data;
    logic        out_ovf;
    logic        out_supply;

    modport master (
        output in_valid,
        output in_word,
        output out_ready,
        input  out_valid,
        input  out_chan,
        input  out_data,
        input  out_ovf,
        input  out_supply
    );

    modport slave (
        input  in_valid,
        input  in_word,
        input  out_ready,
        output out_valid,
        output out_chan,
        output out_data,
        output out_ovf,
        output out_supply
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous reset.
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 29,
    parameter int DEPTH = 4
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge sysclk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ads1258_sample_decoder.sv
// Decodes ADS1258 status+data words, boxcar-averages per channel and
// queues channel-tagged results on a valid/ready stream.
module ads1258_sample_decoder
    import ads1258_pkg::*;
#(
    parameter int         NUM_CH     = 3,
    parameter logic [4:0] CH_BASE    = CHID_AIN0,
    parameter int         AVG_LOG2   = 2,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic                    sysclk,
    input  logic                    rst,
    ads1258_sample_decoder_if.slave bus,
    input  logic                    clear_stats,
    output logic [15:0]             stat_drop_cnt,
    output logic                    stat_overrun
);

    localparam int ACC_W = 24 + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [4:0] chid;
    logic       accept;

    assign chid   = bus.in_word[CHID_HI:CHID_LO];
    assign accept = bus.in_word[NEW_BIT]
                 && chid_enabled(chid, CH_BASE, NUM_CH);

    logic               s1_valid;
    logic [2:0]         s1_idx;
    logic signed [23:0] s1_data;
    logic               s1_ovf;
    logic               s1_sup;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s1_data  <= '0;
            s1_ovf   <= 1'b0;
            s1_sup   <= 1'b0;
        end else begin
            s1_valid <= bus.in_valid && accept;
            s1_idx   <= 3'(chid - CH_BASE);
            s1_data  <= bus.in_word[23:0];
            s1_ovf   <= bus.in_word[OVF_BIT];
            s1_sup   <= bus.in_word[SUP_BIT];
        end
    end

    logic signed [ACC_W-1:0] acc [NUM_CH];
    logic [CNT_W-1:0]        cnt [NUM_CH];
    logic [NUM_CH-1:0]       ovf_s;
    logic [NUM_CH-1:0]       sup_s;

    logic signed [ACC_W-1:0] acc_sel;
    logic signed [ACC_W-1:0] sum;
    logic [CNT_W-1:0]        cnt_sel;
    logic                    ovf_sel;
    logic                    sup_sel;
    logic                    win_done;
    fifo_entry_t             push_entry;

    // The last sample of a window is added here and goes straight to the FIFO.
    always_comb begin
        acc_sel = '0;
        cnt_sel = '0;
        ovf_sel = 1'b0;
        sup_sel = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (s1_idx == 3'(c)) begin
                acc_sel = acc[c];
                cnt_sel = cnt[c];
                ovf_sel = ovf_s[c];
                sup_sel = sup_s[c];
            end
        end
        sum      = acc_sel + ACC_W'(s1_data);
        win_done = s1_valid && (cnt_sel == CNT_LAST);
        push_entry.chan   = s1_idx;
        push_entry.ovf    = ovf_sel | s1_ovf;
        push_entry.supply = sup_sel | s1_sup;
        push_entry.data   = 24'(sum >>> AVG_LOG2);
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc[c] <= '0;
                cnt[c] <= '0;
            end
            ovf_s <= '0;
            sup_s <= '0;
        end else if (s1_valid) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (s1_idx == 3'(c)) begin
                    if (win_done) begin
                        acc[c]   <= '0;
                        cnt[c]   <= '0;
                        ovf_s[c] <= 1'b0;
                        sup_s[c] <= 1'b0;
                    end else begin
                        acc[c]   <= sum;
                        cnt[c]   <= cnt[c] + CNT_W'(1);
                        ovf_s[c] <= ovf_s[c] | s1_ovf;
                        sup_s[c] <= sup_s[c] | s1_sup;
                    end
                end
            end
        end
    end

    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic        overrun_evt;
    fifo_entry_t head;

    assign pop         = bus.out_ready && !fifo_empty;
    assign overrun_evt = win_done && fifo_full && !pop;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sysclk (sysclk),
        .rst    (rst),
        .push   (win_done),
        .wdata  (push_entry),
        .pop    (pop),
        .rdata  (head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign bus.out_valid  = !fifo_empty;
    assign bus.out_chan   = head.chan;
    assign bus.out_data   = head.data;
    assign bus.out_ovf    = head.ovf;
    assign bus.out_supply = head.supply;

    always_ff @(posedge sysclk) begin
        if (rst || clear_stats) begin
            stat_drop_cnt <= '0;
            stat_overrun  <= 1'b0;
        end else begin
            if (bus.in_valid && !accept && stat_drop_cnt != 16'hFFFF) begin
                stat_drop_cnt <= stat_drop_cnt + 16'd1;
            end
            if (overrun_evt) begin
                stat_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ads1258_sample_decoder.sv
// Scoreboard bench: three decoders with AVG_LOG2 = 0, 1, 2 share
// clock, reset and clear; a monitor checks every accepted result.
module tb_ads1258_sample_decoder;
    import ads1258_pkg::*;

    logic sysclk = 1'b0;
    logic rst;
    logic clear_stats;

    always #5 sysclk = ~sysclk;

    ads1258_sample_decoder_if bus0 ();
    ads1258_sample_decoder_if bus1 ();
    ads1258_sample_decoder_if bus2 ();

    logic [2:0]  iv;
    logic [2:0]  rdy;
    logic [31:0] iw [3];
    logic [2:0]  ov;
    logic [2:0]  ovr;
    logic [15:0] drop [3];
    fifo_entry_t got [3];

    assign bus0.in_valid  = iv[0];
    assign bus1.in_valid  = iv[1];
    assign bus2.in_valid  = iv[2];
    assign bus0.in_word   = iw[0];
    assign bus1.in_word   = iw[1];
    assign bus2.in_word   = iw[2];
    assign bus0.out_ready = rdy[0];
    assign bus1.out_ready = rdy[1];
    assign bus2.out_ready = rdy[2];
    assign ov = {bus2.out_valid, bus1.out_valid, bus0.out_valid};
    assign got[0] = {bus0.out_chan, bus0.out_ovf, bus0.out_supply, bus0.out_data};
    assign got[1] = {bus1.out_chan, bus1.out_ovf, bus1.out_supply, bus1.out_data};
    assign got[2] = {bus2.out_chan, bus2.out_ovf, bus2.out_supply, bus2.out_data};

    ads1258_sample_decoder #(.AVG_LOG2(0)) u_dut0 (
        .sysclk(sysclk), .rst(rst), .bus(bus0.slave),
        .clear_stats(clear_stats),
        .stat_drop_cnt(drop[0]), .stat_overrun(ovr[0])
    );
    ads1258_sample_decoder #(.AVG_LOG2(1)) u_dut1 (
        .sysclk(sysclk), .rst(rst), .bus(bus1.slave),
        .clear_stats(clear_stats),
        .stat_drop_cnt(drop[1]), .stat_overrun(ovr[1])
    );
    ads1258_sample_decoder #(.AVG_LOG2(2)) u_dut2 (
        .sysclk(sysclk), .rst(rst), .bus(bus2.slave),
        .clear_stats(clear_stats),
        .stat_drop_cnt(drop[2]), .stat_overrun(ovr[2])
    );

    int checks = 0;
    int errors = 0;
    bit done = 1'b0;
    fifo_entry_t exp_q [3][$];

    function automatic fifo_entry_t mk(input logic [2:0] ch, input logic o,
                                       input logic s, input logic [23:0] d);
        return {ch, o, s, d};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input int k, input logic [31:0] w);
        iv[k] = 1'b1;
        iw[k] = w;
        step();
        iv[k] = 1'b0;
    endtask

    task automatic monitor();
        while (!done) begin
            @(negedge sysclk);
            for (int k = 0; k < 3; k++) begin
                if (ov[k] && rdy[k]) begin
                    checks++;
                    if (exp_q[k].size() == 0) begin
                        errors++;
                        $display("FAIL dut%0d_unexpected: got 0x%0h expected none",
                                 k, got[k]);
                    end else begin
                        fifo_entry_t e;
                        e = exp_q[k].pop_front();
                        if (got[k] !== e) begin
                            errors++;
                            $display("FAIL dut%0d_result: got 0x%0h expected 0x%0h",
                                     k, got[k], e);
                        end
                    end
                end
            end
        end
    endtask

    task automatic stimulus();
        iv = '0;
        rdy = '1;
        for (int k = 0; k < 3; k++) iw[k] = '0;
        clear_stats = 1'b0;
        rst = 1'b1;
        idle(3);
        @(negedge sysclk);
        chk("rst_valid", 32'(ov), 32'd0);
        chk("rst_head", 32'(got[0]), 32'd0);
        chk("rst_drop", 32'(drop[0]), 32'd0);
        chk("rst_overrun", 32'(ovr), 32'd0);
        step();
        rst = 1'b0;
        step();

        // pass-through and two-cycle latency
        exp_q[0].push_back(mk(3'd0, 1'b0, 1'b0, 24'h123456));
        send(0, 32'h88123456);
        @(negedge sysclk);
        chk("lat_cycle1", 32'(ov[0]), 32'd0);
        step();
        @(negedge sysclk);
        chk("lat_cycle2", 32'(ov[0]), 32'd1);
        idle(3);

        // four-sample average on CHID 0x09
        exp_q[2].push_back(mk(3'd1, 1'b0, 1'b0, 24'h000002));
        send(2, 32'h89000004);
        send(2, 32'h89000008);
        send(2, 32'h89FFFFFC);
        send(2, 32'h89000000);
        idle(4);

        // floor shift of -5/2 on the last channel, sticky SUPPLY
        exp_q[1].push_back(mk(3'd2, 1'b0, 1'b1, 24'hFFFFFD));
        send(1, 32'hAAFFFFFE);
        send(1, 32'h8AFFFFFD);
        idle(4);

        // drops and statistics clear
        send(0, 32'h08000001);
        send(0, 32'h9F000001);
        @(negedge sysclk);
        chk("drop_two", 32'(drop[0]), 32'd2);
        step();
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        @(negedge sysclk);
        chk("drop_clear", 32'(drop[0]), 32'd0);
        step();
        send(0, {1'b1, 2'b00, CHID_SYS0, 24'h000000});
        send(0, 32'h8B000000);
        send(0, 32'h87000000);
        @(negedge sysclk);
        chk("drop_bounds", 32'(drop[0]), 32'd3);
        step();
        clear_stats = 1'b1;
        send(0, 32'h08000000);
        clear_stats = 1'b0;
        @(negedge sysclk);
        chk("clear_wins", 32'(drop[0]), 32'd0);
        step();

        // interleaved channels, OVF in ch0 window
        exp_q[1].push_back(mk(3'd0, 1'b1, 1'b0, 24'd20));
        exp_q[1].push_back(mk(3'd1, 1'b0, 1'b0, 24'd30));
        send(1, 32'h8800000A);
        send(1, 32'h89000014);
        send(1, 32'hC800001E);
        send(1, 32'h89000028);
        idle(4);

        // overrun with consumer stalled
        rdy[0] = 1'b0;
        for (int i = 1; i <= 4; i++)
            exp_q[0].push_back(mk(3'd0, 1'b0, 1'b0, 24'(i)));
        for (int i = 1; i <= 5; i++) send(0, 32'h88000000 | 32'(i));
        step();
        @(negedge sysclk);
        chk("overrun_set", 32'(ovr[0]), 32'd1);
        chk("full_valid", 32'(ov[0]), 32'd1);
        chk("head_first", 32'(got[0]), 32'(mk(3'd0, 1'b0, 1'b0, 24'd1)));
        idle(2);
        @(negedge sysclk);
        chk("head_stable", 32'(got[0]), 32'(mk(3'd0, 1'b0, 1'b0, 24'd1)));
        step();
        rdy[0] = 1'b1;
        idle(6);
        @(negedge sysclk);
        chk("drained", 32'(ov[0]), 32'd0);
        step();
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        @(negedge sysclk);
        chk("overrun_clear", 32'(ovr[0]), 32'd0);
        step();

        // push into a full FIFO while the head is popped
        rdy[0] = 1'b0;
        for (int i = 17; i <= 21; i++)
            exp_q[0].push_back(mk(3'd0, 1'b0, 1'b0, 24'(i)));
        for (int i = 17; i <= 21; i++) send(0, 32'h88000000 | 32'(i));
        rdy[0] = 1'b1;
        idle(8);
        @(negedge sysclk);
        chk("full_pop_push", 32'(ovr[0]), 32'd0);
        step();

        // reset mid-window discards the partial sum
        send(2, 32'h88000064);
        send(2, 32'h88000064);
        send(2, 32'h88000064);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q[2].push_back(mk(3'd0, 1'b0, 1'b0, 24'd3));
        send(2, 32'h88000001);
        send(2, 32'h88000002);
        send(2, 32'h88000003);
        send(2, 32'h88000006);
        idle(10);
    endtask

    initial begin
        fork
            monitor();
            begin
                stimulus();
                done = 1'b1;
            end
        join
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (exp_q[k].size() != 0) begin
                errors++;
                $display("FAIL dut%0d_missing: got %0d pending expected 0",
                         k, exp_q[k].size());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ads1258_sample_decoder.md
Name: ads1258_sample_decoder

Overview:
Consumes the 32-bit status+data words assembled by the ADS1258 SPI controller (one qualifying strobe per conversion read). It decodes the status byte, drops stale or out-of-range readings, and routes each reading to a per-channel accumulator. The accumulator performs 2^AVG_LOG2 boxcar decimation. Averaged, channel-tagged results are buffered in a small FIFO and drained over a valid/ready interface to the downstream display/UART formatter.

Parameters:
NUM_CH, 3, number of enabled single-ended channels (1..8)
CH_BASE, 5'h08, CHID of the first channel (AIN0 = 0x08)
AVG_LOG2, 2, log2 of samples averaged per result (0..6; 0 = pass-through)
FIFO_DEPTH, 4, output FIFO entries (power of two, >= 2)

Ports:
sysclk  in  1  system clock
rst  in  1  synchronous active-high reset
in_valid  in  1  one-cycle strobe; in_word is valid in this cycle
in_word  in  32  [31]=NEW, [30]=OVF, [29]=SUPPLY, [28:24]=CHID, [23:0]=two's-complement data
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head when out_valid & out_ready
out_chan  out  3  channel index (CHID - CH_BASE)
out_data  out  24  signed averaged result
out_ovf  out  1  any sample in the averaging window had OVF=1
out_supply  out  1  any sample in the averaging window had SUPPLY=1
clear_stats  in  1  synchronous clear of the statistics outputs
stat_drop_cnt  out  16  count of discarded input words, saturating at 0xFFFF
stat_overrun  out  1  sticky flag: a result was lost because the FIFO was full

Behaviour:
- Reset (rst=1 at a sysclk edge):
  - out_valid=0; out_chan=0; out_data=0; out_ovf=0; out_supply=0.
  - stat_drop_cnt=0; stat_overrun=0.
  - All accumulators, sample counters and sticky flags cleared; FIFO emptied; pipeline valid bits cleared.
  - Reset mid-window discards partial sums. No output is produced for a partial window.
- Stage 1 (edge where in_valid=1): register in_word and compute idx = CHID - CH_BASE. The word is accepted only when NEW=1 and CH_BASE <= CHID < CH_BASE+NUM_CH.
- Rejected word: stat_drop_cnt increments in stage 1. No accumulator changes.
- Stage 2 (next edge), accepted word:
  - acc[idx] += sign_extend(data) into a (24+AVG_LOG2)-bit register.
  - cnt[idx] increments.
  - ovf_s[idx] |= OVF; sup_s[idx] |= SUPPLY.
- Window completion: when cnt[idx] reaches 2^AVG_LOG2-1 before the add, the same edge:
  - Pushes {idx, (acc+data)>>>AVG_LOG2, ovf_s|OVF, sup_s|SUPPLY} into the FIFO.
  - Clears acc/cnt/ovf_s/sup_s for that channel.
  - The shift is arithmetic (floor). Example: sum -5 with AVG_LOG2=1 gives -3.
- Latency: with the FIFO empty, out_valid rises 2 cycles after the in_valid cycle of the completing sample.
- Throughput: in_valid may assert every cycle, including same-channel back-to-back. Accumulators are flops read and written in one cycle, so no hazard exists.
- FIFO full on push: the result is discarded and stat_overrun is set. The channel's window is still cleared.
- Pop and push in the same cycle while full: the push succeeds.
- Outputs are driven from the FIFO head register. They hold stable while out_valid=1 and out_ready=0.
- clear_stats=1: stat_drop_cnt=0 and stat_overrun=0. If a drop or overrun occurs in the same cycle, clear wins.
- Channels are independent: interleaved channel sequences average per channel, and results emerge in completion order.

Decomposition:
- Package ads1258_pkg holds the status bit positions (NEW=31, OVF=30, SUPPLY=29, CHID=28:24) and the CHID constants (AIN0=0x08, first system reading 0x18).
- It also holds the FIFO entry layout: {chan[2:0], ovf, supply, data[23:0]} = 29 bits.
- Sub-module: sync_fifo (parameterised width/depth, first-word-fall-through, full/empty, single clock, sync active-high reset).

Test Plan:
1. AVG_LOG2=0, in_word=0x88_123456 -> out_valid 2 cycles later; chan=0, data=0x123456, ovf=0, supply=0.
2. AVG_LOG2=2, CHID 0x09, data 0x000004, 0x000008, 0xFFFFFC, 0x000000 -> exactly one output after the 4th word: chan=1, data=0x000002.
3. in_word=0x08_000001 (NEW=0) and 0x9F_000001 (CHID out of range) -> no output; stat_drop_cnt=2. Then clear_stats -> 0.
4. AVG_LOG2=1, interleaved ch0/ch1/ch0/ch1 with data 10,20,30,40; second ch0 word has OVF=1 -> outputs (ch0, 20, ovf=1) then (ch1, 30, ovf=0).
5. out_ready=0, AVG_LOG2=0, 5 accepted words back-to-back -> 4 entries held and stable, stat_overrun=1. Drain -> first four in order.
6. rst pulsed after 3 of 4 samples -> no output; next 4 samples produce an average of those 4 only.
